tracer_udma_rx_ctrl: RTL and testbench

uDMA RX channel controller for the trace debugger, directly downstream of the tracer register interface. It consumes the latched channel configuration (start address, size, datasize, continuous, en/clr pulses). It converts the incoming 32-bit trace packet stream into L2 write requests with address generation. It reports live status (current address, bytes left, enabled, pending) back for register readout.

---
 rtl/tracer_udma_rx_ctrl_if.sv | 25 ++
 rtl/tracer_udma_rx_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_tracer_udma_rx_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tracer_udma_rx_ctrl_if.sv
// Trace RX stream and L2 write-request bundle for tracer_udma_rx_ctrl.
// The master side is the controller: it accepts trace packets and issues
// L2 write requests. The slave side is the trace source / L2 arbiter.
interface tracer_udma_rx_ctrl_if #(
  parameter int L2_AWIDTH_NOAL = 12
);
  logic [31:0]               data_i;
  logic                      data_valid_i;
  logic                      data_ready_o;
  logic [L2_AWIDTH_NOAL-1:0] req_addr_o;
  logic [31:0]               req_data_o;
  logic [1:0]                req_datasize_o;
  logic                      req_valid_o;
  logic                      req_gnt_i;

  modport master (
    input  data_i, data_valid_i, req_gnt_i,
    output data_ready_o, req_addr_o, req_data_o, req_datasize_o, req_valid_o
  );

  modport slave (
    output data_i, data_valid_i, req_gnt_i,
    input  data_ready_o, req_addr_o, req_data_o, req_datasize_o, req_valid_o
  );
endinterface

// File: rtl/tracer_udma_rx_ctrl.sv
// uDMA RX channel controller for the trace debugger.
// Turns the 32-bit trace packet stream into L2 write requests, generating
// addresses from the latched channel configuration and reporting live
// status (current address, bytes left, enabled, pending).
// Optional feature macro TRACER_RX_DROP_EN: when defined, packets arriving
// while the channel is idle are accepted and discarded, and counted on
// drop_cnt_o (saturating). When undefined, the source is back-pressured.
module tracer_udma_rx_ctrl #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  output logic                      evt_eot_o,
`ifdef TRACER_RX_DROP_EN
  output logic [15:0]               drop_cnt_o,
`endif
  tracer_udma_rx_ctrl_if.master     rx
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [L2_AWIDTH_NOAL-1:0] curr_addr_q, curr_addr_d;
  logic [TRANS_SIZE-1:0]     bytes_left_q, bytes_left_d;
  logic [1:0]                datasize_q, datasize_d;
  logic                      pending_q, pending_d;
  logic [L2_AWIDTH_NOAL-1:0] sh_addr_q, sh_addr_d;
  logic [TRANS_SIZE-1:0]     sh_size_q, sh_size_d;
  logic [1:0]                sh_datasize_q, sh_datasize_d;
  logic                      eot_q, eot_d;

  logic [L2_AWIDTH_NOAL-1:0] req_addr_q;
  logic [31:0]               req_data_q;
  logic [1:0]                req_datasize_q;
  logic                      req_valid_q;

  logic [2:0]                stride;
  logic                      ready;
  logic                      accept;
  logic                      last_beat;
  logic                      en_ok;

  // Byte stride per beat; datasize 3 behaves like a word.
  always_comb begin
    stride = 3'd4;
    case (datasize_q)
      2'd0:    stride = 3'd1;
      2'd1:    stride = 3'd2;
      default: stride = 3'd4;
    endcase
  end

  // Output register can take a new beat when empty or being drained this cycle.
`ifdef TRACER_RX_DROP_EN
  assign ready = (state_q == IDLE) | (~req_valid_q | rx.req_gnt_i);
`else
  assign ready = (state_q == RUN) & (~req_valid_q | rx.req_gnt_i);
`endif

  assign accept    = rx.data_valid_i & ready & (state_q == RUN);
  assign last_beat = accept & (bytes_left_q <= TRANS_SIZE'(stride));
  assign en_ok     = cfg_en_i & (cfg_size_i != '0);

  // Next-state and address generation; clear dominates everything else.
  always_comb begin
    state_d       = state_q;
    curr_addr_d   = curr_addr_q;
    bytes_left_d  = bytes_left_q;
    datasize_d    = datasize_q;
    pending_d     = pending_q;
    sh_addr_d     = sh_addr_q;
    sh_size_d     = sh_size_q;
    sh_datasize_d = sh_datasize_q;
    eot_d         = 1'b0;

    if (cfg_clr_i) begin
      state_d      = IDLE;
      pending_d    = 1'b0;
      bytes_left_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_ok) begin
            curr_addr_d  = cfg_startaddr_i;
            bytes_left_d = cfg_size_i;
            datasize_d   = cfg_datasize_i;
            state_d      = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            curr_addr_d  = curr_addr_q + L2_AWIDTH_NOAL'(stride);
            bytes_left_d = (bytes_left_q > TRANS_SIZE'(stride))
                         ? bytes_left_q - TRANS_SIZE'(stride) : '0;
          end
          if (last_beat) begin
            eot_d = 1'b1;
            if (en_ok) begin
              curr_addr_d  = cfg_startaddr_i;
              bytes_left_d = cfg_size_i;
              datasize_d   = cfg_datasize_i;
              pending_d    = 1'b0;
            end else if (pending_q) begin
              curr_addr_d  = sh_addr_q;
              bytes_left_d = sh_size_q;
              datasize_d   = sh_datasize_q;
              pending_d    = 1'b0;
            end else if (cfg_continuous_i && (cfg_size_i != '0)) begin
              curr_addr_d  = cfg_startaddr_i;
              bytes_left_d = cfg_size_i;
              datasize_d   = cfg_datasize_i;
            end else begin
              state_d = IDLE;
            end
          end else if (en_ok) begin
            sh_addr_d     = cfg_startaddr_i;
            sh_size_d     = cfg_size_i;
            sh_datasize_d = cfg_datasize_i;
            pending_d     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Channel state and configuration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      curr_addr_q   <= '0;
      bytes_left_q  <= '0;
      datasize_q    <= '0;
      pending_q     <= 1'b0;
      sh_addr_q     <= '0;
      sh_size_q     <= '0;
      sh_datasize_q <= '0;
      eot_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      curr_addr_q   <= curr_addr_d;
      bytes_left_q  <= bytes_left_d;
      datasize_q    <= datasize_d;
      pending_q     <= pending_d;
      sh_addr_q     <= sh_addr_d;
      sh_size_q     <= sh_size_d;
      sh_datasize_q <= sh_datasize_d;
      eot_q         <= eot_d;
    end
  end

  // One-deep request register: holds until granted, even across a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      req_datasize_q <= '0;
    end else if (accept) begin
      req_valid_q    <= 1'b1;
      req_addr_q     <= curr_addr_q;
      req_data_q     <= rx.data_i;
      req_datasize_q <= datasize_q;
    end else if (rx.req_gnt_i) begin
      req_valid_q    <= 1'b0;
    end
  end

`ifdef TRACER_RX_DROP_EN
  logic [15:0] drop_cnt_q;

  // Count packets swallowed while idle, saturating; clear resets it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (cfg_clr_i) begin
      drop_cnt_q <= '0;
    end else if ((state_q == IDLE) && rx.data_valid_i && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign cfg_en_o          = (state_q == RUN);
  assign cfg_pending_o     = pending_q;
  assign cfg_curr_addr_o   = curr_addr_q;
  assign cfg_bytes_left_o  = bytes_left_q;
  assign evt_eot_o         = eot_q;
  assign rx.data_ready_o   = ready;
  assign rx.req_addr_o     = req_addr_q;
  assign rx.req_data_o     = req_data_q;
  assign rx.req_datasize_o = req_datasize_q;
  assign rx.req_valid_o    = req_valid_q;

endmodule

// File: tb/tb_tracer_udma_rx_ctrl.sv
// Self-checking bench for tracer_udma_rx_ctrl: directed scenarios followed by
// randomized traffic, scored against a transfer-level reference model.
module tb_tracer_udma_rx_ctrl;

  localparam int AW = 12;
  localparam int TS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfgStart;
  logic [TS-1:0] cfgSize;
  logic [1:0]    cfgDs;
  logic          cfgCont;
  logic          cfgEn;
  logic          cfgClr;
  logic          enOut;
  logic          pendOut;
  logic [AW-1:0] currAddr;
  logic [TS-1:0] bytesLeft;
  logic          eotOut;
`ifdef TRACER_RX_DROP_EN
  logic [15:0]   dropCnt;
`endif

  tracer_udma_rx_ctrl_if #(.L2_AWIDTH_NOAL(AW)) rx ();

  tracer_udma_rx_ctrl #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_startaddr_i  (cfgStart),
    .cfg_size_i       (cfgSize),
    .cfg_datasize_i   (cfgDs),
    .cfg_continuous_i (cfgCont),
    .cfg_en_i         (cfgEn),
    .cfg_clr_i        (cfgClr),
    .cfg_en_o         (enOut),
    .cfg_pending_o    (pendOut),
    .cfg_curr_addr_o  (currAddr),
    .cfg_bytes_left_o (bytesLeft),
    .evt_eot_o        (eotOut),
`ifdef TRACER_RX_DROP_EN
    .drop_cnt_o       (dropCnt),
`endif
    .rx               (rx.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    ds;
  } req_t;

  req_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a transfer is (start, size, stride) plus a beat index.
  bit   mActive, mPending, mReqValid, mEot;
  int   mStart, mSize, mStride, mBeat;
  logic [1:0] mDs;
  int   shStart, shSize;
  logic [1:0] shDs;
  int   mDrop;

  function automatic int strideOf(logic [1:0] ds);
    return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [AW-1:0] expAddr();
    return AW'(mStart + mBeat * mStride);
  endfunction

  function automatic int expLeft();
    int r;
    r = mSize - mBeat * mStride;
    return (r > 0) ? r : 0;
  endfunction

  function automatic bit expReady();
`ifdef TRACER_RX_DROP_EN
    if (!mActive) return 1'b1;
`endif
    return mActive && (!mReqValid || rx.req_gnt_i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mPending = 0; mReqValid = 0; mEot = 0;
    mStart = 0; mSize = 0; mStride = 1; mBeat = 0; mDs = 2'd0;
    shStart = 0; shSize = 0; shDs = 2'd0; mDrop = 0;
    expQ.delete();
  endtask

  task automatic loadCfg(input int st, input int sz, input logic [1:0] ds);
    mStart = st; mSize = sz; mDs = ds; mStride = strideOf(ds); mBeat = 0; mActive = 1;
  endtask

  task automatic checkOutput();
    check("cfg_en_o", 32'(enOut), 32'(mActive));
    check("cfg_pending_o", 32'(pendOut), 32'(mPending));
    check("cfg_curr_addr_o", 32'(currAddr), 32'(expAddr()));
    check("cfg_bytes_left_o", 32'(bytesLeft), 32'(expLeft()));
    check("evt_eot_o", 32'(eotOut), 32'(mEot));
    check("req_valid_o", 32'(rx.req_valid_o), 32'(mReqValid));
    check("data_ready_o", 32'(rx.data_ready_o), 32'(expReady()));
`ifdef TRACER_RX_DROP_EN
    check("drop_cnt_o", 32'(dropCnt), 32'(mDrop));
`endif
  endtask

  // One clock: check status at the falling edge, advance the model, cross the edge.
  task automatic step();
    bit   acc, last, enOk;
    req_t r;
    @(negedge clk);
    checkOutput();
    enOk = cfgEn && (cfgSize != 0);
    acc  = rx.data_valid_i && expReady() && mActive;
    last = acc && ((mSize - mBeat * mStride) <= mStride);
    mEot = 1'b0;
    if (acc) begin
      r.addr = expAddr(); r.data = rx.data_i; r.ds = mDs;
      expQ.push_back(r);
    end
    if (acc) mReqValid = 1'b1;
    else if (rx.req_gnt_i) mReqValid = 1'b0;
`ifdef TRACER_RX_DROP_EN
    if (cfgClr) mDrop = 0;
    else if (!mActive && rx.data_valid_i && mDrop < 65535) mDrop++;
`endif
    if (cfgClr) begin
      mActive = 0; mPending = 0; mSize = 0;
    end else if (!mActive) begin
      if (enOk) loadCfg(int'(cfgStart), int'(cfgSize), cfgDs);
    end else begin
      if (acc) mBeat++;
      if (last) begin
        mEot = 1'b1;
        if (enOk) begin
          loadCfg(int'(cfgStart), int'(cfgSize), cfgDs); mPending = 0;
        end else if (mPending) begin
          loadCfg(shStart, shSize, shDs); mPending = 0;
        end else if (cfgCont && cfgSize != 0) begin
          loadCfg(int'(cfgStart), int'(cfgSize), cfgDs);
        end else begin
          mActive = 0;
        end
      end else if (enOk) begin
        shStart = int'(cfgStart); shSize = int'(cfgSize); shDs = cfgDs; mPending = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input logic [AW-1:0] st,
                               input logic [TS-1:0] sz, input logic [1:0] ds,
                               input bit valid, input bit gnt, input logic [31:0] data);
    cfgEn = en; cfgClr = clr; cfgStart = st; cfgSize = sz; cfgDs = ds;
    rx.data_valid_i = valid && !clr; rx.req_gnt_i = gnt; rx.data_i = data;
    step();
  endtask

  // Feed packets with grant high until the channel and output stage are empty.
  task automatic drain();
    int n;
    n = 0;
    while ((mActive || mReqValid) && n < 100) begin
      applyStimulus(0, 0, cfgStart, cfgSize, cfgDs, 1, 1, $urandom);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'd1, 32'd0);
    applyStimulus(0, 0, cfgStart, cfgSize, cfgDs, 0, 1, 32'd0);
  endtask

  // Scoreboard monitor: every granted write must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rx.req_valid_o && rx.req_gnt_i) begin
      if (expQ.size() == 0) begin
        check("unexpected_write", 32'(rx.req_addr_o), 32'hFFFF_FFFF);
      end else begin
        req_t e;
        e = expQ.pop_front();
        check("req_addr_o", 32'(rx.req_addr_o), 32'(e.addr));
        check("req_data_o", rx.req_data_o, e.data);
        check("req_datasize_o", 32'(rx.req_datasize_o), 32'(e.ds));
      end
    end
  end

  initial begin
    rst = 1'b1; cfgStart = '0; cfgSize = '0; cfgDs = '0; cfgCont = 0; cfgEn = 0; cfgClr = 0;
    rx.data_i = '0; rx.data_valid_i = 0; rx.req_gnt_i = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", 32'(enOut), 32'd0);
    check("reset_req_valid", 32'(rx.req_valid_o), 32'd0);
    check("reset_bytes_left", 32'(bytesLeft), 32'd0);
    check("reset_eot", 32'(eotOut), 32'd0);
    rst = 1'b0;

    $display("[TB] basic transfer");
    applyStimulus(1, 0, 12'h100, 16'd8, 2'd2, 0, 1, 32'd0);
    applyStimulus(0, 0, 12'h100, 16'd8, 2'd2, 1, 1, 32'hA0A0_0001);
    applyStimulus(0, 0, 12'h100, 16'd8, 2'd2, 1, 1, 32'hA0A0_0002);
    repeat (2) applyStimulus(0, 0, 12'h100, 16'd8, 2'd2, 1, 1, 32'hDEAD_0000);

    $display("[TB] backpressure");
    applyStimulus(1, 0, 12'h040, 16'd16, 2'd2, 0, 0, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 12'h040, 16'd16, 2'd2, 1, 0, 32'hB000_0000 + 32'(i));
    applyStimulus(0, 0, 12'h040, 16'd16, 2'd2, 0, 1, 32'd0);
    drain();

    $display("[TB] pending then continuous");
    applyStimulus(1, 0, 12'h010, 16'd4, 2'd2, 0, 1, 32'd0);
    applyStimulus(1, 0, 12'h200, 16'd8, 2'd2, 0, 1, 32'd0);
    applyStimulus(0, 0, 12'h200, 16'd8, 2'd2, 1, 1, 32'hC000_0001);
    drain();
    cfgCont = 1'b1;
    applyStimulus(1, 0, 12'h300, 16'd4, 2'd2, 0, 1, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 12'h300, 16'd4, 2'd2, 1, 1, 32'hC100_0000 + 32'(i));
    cfgCont = 1'b0;
    drain();

    $display("[TB] partial beat with address wrap");
    applyStimulus(1, 0, 12'hFFE, 16'd6, 2'd2, 0, 1, 32'd0);
    drain();
    applyStimulus(1, 0, 12'hFFF, 16'd3, 2'd1, 0, 1, 32'd0);
    drain();

    $display("[TB] clear with simultaneous enable");
    applyStimulus(1, 0, 12'h080, 16'd16, 2'd2, 0, 0, 32'd0);
    applyStimulus(0, 0, 12'h080, 16'd16, 2'd2, 1, 0, 32'hE000_0001);
    applyStimulus(1, 1, 12'h400, 16'd8, 2'd2, 0, 0, 32'd0);
    applyStimulus(0, 0, 12'h400, 16'd8, 2'd2, 0, 0, 32'd0);
    applyStimulus(0, 0, 12'h400, 16'd8, 2'd2, 0, 1, 32'd0);
    applyStimulus(0, 0, 12'h400, 16'd8, 2'd2, 0, 1, 32'd0);

`ifdef TRACER_RX_DROP_EN
    $display("[TB] drop while idle");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 12'h0, 16'd4, 2'd2, 1, 1, 32'hF000_0000);
    applyStimulus(0, 1, 12'h0, 16'd4, 2'd2, 0, 1, 32'd0);
    applyStimulus(0, 0, 12'h0, 16'd4, 2'd2, 0, 1, 32'd0);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) cfgCont = $urandom_range(0, 1) == 1;
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
                    AW'($urandom), TS'($urandom_range(0, 24)), 2'($urandom),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom);
    end
    cfgCont = 1'b0;
    drain();

    $display("[TB] asynchronous reset mid-transfer");
    applyStimulus(1, 0, 12'h500, 16'd16, 2'd2, 0, 0, 32'd0);
    applyStimulus(0, 0, 12'h500, 16'd16, 2'd2, 1, 0, 32'h1234_5678);
    rx.data_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_req_valid", 32'(rx.req_valid_o), 32'd0);
    check("async_rst_en", 32'(enOut), 32'd0);
    check("async_rst_bytes_left", 32'(bytesLeft), 32'd0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 12'h0, 16'd0, 2'd0, 0, 1, 32'd0);
    applyStimulus(0, 0, 12'h0, 16'd0, 2'd0, 0, 1, 32'd0);

    check("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
